irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
Machine-level interrupt source for the 3-stage core. It drives the interrupt request and cause into the CSR register file, which computes the trap vector, saves the PC and flushes fetch. The block also owns a memory-mapped machine timer (mtime/mtimecmp). It synchronises the UART/external interrupt line, applies the mstatus/mie enables, arbitrates, issues one trap and then waits for mret before issuing another.

Parameters:
PRESCALE, 1, clk_o cycles per mtime increment (>=1)
SYNC_STAGES, 2, flip-flop stages on ext_irq (>=2)

Ports:
clk_o  in  1  core clock
reset  in  1  synchronous, active-high reset
ext_irq  in  1  asynchronous level interrupt from UART/peripheral
mstatus_mie  in  1  mstatus[3], global machine interrupt enable
mie_meie  in  1  mie[11], external interrupt enable
mie_mtie  in  1  mie[7], timer interrupt enable
mret_i  in  1  one-cycle pulse when mret is in the execute stage
tmr_we  in  1  timer register write strobe
tmr_addr  in  1  0 = mtime, 1 = mtimecmp
tmr_wdata  in  32  timer write data
tmr_rdata  out  32  timer read data, combinational on tmr_addr
intrrupt  out  1  one-cycle trap request to the CSR file
csr_mcause  out  32  cause of the last issued trap
mip  out  32  pending bits: bit 11 = meip, bit 7 = mtip, all other bits 0
in_service  out  1  trap taken, mret not yet seen

Behaviour:
- Reset values (synchronous, active-high, at the clk_o edge with reset=1): mtime=0, mtimecmp=32'hFFFF_FFFF, prescaler=0, sync chain=0, state=IDLE, intrrupt=0, csr_mcause=0, in_service=0. Reset mid-service returns the block to IDLE at once.
- Timer:
  - Prescaler counts 0..PRESCALE-1; mtime increments when it wraps.
  - mtime wraps 32'hFFFF_FFFF -> 0.
  - A tmr_we write to mtime loads tmr_wdata and clears the prescaler; the write wins over a same-cycle increment.
  - mtimecmp is written only through tmr_we.
- mtip = (mtime >= mtimecmp), unsigned, level, combinational from the registers. It clears only by software rewriting mtimecmp or mtime.
- meip is the output of the SYNC_STAGES flop chain on ext_irq, level sensitive.
- mip = {20'b0, meip, 3'b0, mtip, 7'b0}.
- take_ext = meip & mie_meie & mstatus_mie. take_tmr = mtip & mie_mtie & mstatus_mie.
- Priority: external over timer.
- FSM states: IDLE, ISSUE, SERVICE.
  - IDLE: if take_ext, latch csr_mcause=32'h8000_000B and go to ISSUE. Else if take_tmr, latch csr_mcause=32'h8000_0007 and go to ISSUE.
  - ISSUE: intrrupt=1 for exactly this cycle; next state is SERVICE.
  - SERVICE: in_service=1; stay until mret_i=1, then go to IDLE.
- intrrupt is high only in ISSUE, so it is a registered one-cycle pulse.
- in_service is 1 in both ISSUE and SERVICE.
- csr_mcause holds its value until the next issue.
- mret_i in IDLE or ISSUE is ignored.
- mret_i in SERVICE with an interrupt still pending: the FSM goes to IDLE, and the next ISSUE comes no earlier than 2 cycles after the mret cycle. This guarantees a gap.
- Enables drop while in ISSUE: the trap already being issued still completes.
- Latency: ext_irq high and stable before edge N (with SYNC_STAGES=2 and enables set) gives meip=1 after edge N+1, state=ISSUE after edge N+2, so intrrupt is high in the cycle after edge N+2.
- Timer latency: the edge where mtime becomes equal to mtimecmp moves to ISSUE on the following edge.

Decomposition:
- Shared package core_pkg holds:
  - the irq_state_e enum (IDLE, ISSUE, SERVICE);
  - MCAUSE_MEI = 32'h8000_000B and MCAUSE_MTI = 32'h8000_0007;
  - MIP_MEIP_BIT = 11 and MIP_MTIP_BIT = 7;
  - TMR_ADDR_MTIME = 0 and TMR_ADDR_MTIMECMP = 1.
- One sub-module, mtimer: prescaler, mtime, mtimecmp, register read/write and mtip. The FSM, synchroniser and arbitration stay in irq_ctrl.

Test Plan:
- Reset, then read both addresses -> tmr_rdata = 0 for mtime and 32'hFFFF_FFFF for mtimecmp. intrrupt, mip and in_service all stay 0 for 20 cycles.
- Enables set, ext_irq raised before edge N -> intrrupt is a 1-cycle pulse after edge N+2, csr_mcause=32'h8000_000B, in_service=1 until mret_i. A 2nd trap comes only after mret_i.
- PRESCALE=4, write mtimecmp=5, mtime=0 -> mtip=1 after 20 cycles; trap with csr_mcause=32'h8000_0007 follows one cycle later.
- ext_irq and mtip pending in the same cycle -> external issues first. After mret_i the timer trap issues at least 2 cycles after the mret cycle.
- mstatus_mie=0 with both pending -> mip=32'h0000_0880 and no intrrupt. Raising mstatus_mie -> trap issues on the next edge.
- Write mtime=32'hFFFF_FFFF -> mtime reads 0 after one increment. Assert reset while in SERVICE -> state IDLE, in_service=0 and mtimecmp=32'hFFFF_FFFF on the next edge.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for the machine interrupt controller
package core_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SERVICE
  } irq_state_e;

  localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] MCAUSE_MTI = 32'h8000_0007;

  localparam int MIP_MEIP_BIT = 11;
  localparam int MIP_MTIP_BIT = 7;

  localparam logic TMR_ADDR_MTIME    = 1'b0;
  localparam logic TMR_ADDR_MTIMECMP = 1'b1;

endpackage

// File: rtl/mtimer.sv
// rtl/mtimer.sv - memory-mapped machine timer: prescaler, mtime, mtimecmp and mtip
module mtimer
  import core_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk_o,
  input  logic        reset,
  input  logic        tmr_we,
  input  logic        tmr_addr,
  input  logic [31:0] tmr_wdata,
  output logic [31:0] tmr_rdata,
  output logic        mtip
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] prescaler;
  logic [31:0]   mtime;
  logic [31:0]   mtimecmp;
  logic          tick;

  assign tick = (prescaler == PW'(PRESCALE - 1));

  always_ff @(posedge clk_o) begin
    if (reset) begin
      prescaler <= '0;
      mtime     <= '0;
      mtimecmp  <= 32'hFFFF_FFFF;
    end else begin
      // A software write to mtime restarts the prescale period and beats any tick.
      if (tmr_we && tmr_addr == TMR_ADDR_MTIME) begin
        mtime     <= tmr_wdata;
        prescaler <= '0;
      end else begin
        prescaler <= tick ? '0 : prescaler + 1'b1;
        if (tick) mtime <= mtime + 32'd1;
      end
      if (tmr_we && tmr_addr == TMR_ADDR_MTIMECMP) mtimecmp <= tmr_wdata;
    end
  end

  assign tmr_rdata = (tmr_addr == TMR_ADDR_MTIMECMP) ? mtimecmp : mtime;
  assign mtip      = (mtime >= mtimecmp);

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - machine interrupt source: ext_irq synchroniser, enables, arbitration and trap FSM
module irq_ctrl
  import core_pkg::*;
#(
  parameter int PRESCALE    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_o,
  input  logic        reset,
  input  logic        ext_irq,
  input  logic        mstatus_mie,
  input  logic        mie_meie,
  input  logic        mie_mtie,
  input  logic        mret_i,
  input  logic        tmr_we,
  input  logic        tmr_addr,
  input  logic [31:0] tmr_wdata,
  output logic [31:0] tmr_rdata,
  output logic        intrrupt,
  output logic [31:0] csr_mcause,
  output logic [31:0] mip,
  output logic        in_service
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   meip;
  logic                   mtip;
  logic                   take_ext;
  logic                   take_tmr;
  irq_state_e             state;

  mtimer #(.PRESCALE(PRESCALE)) u_mtimer (
    .clk_o     (clk_o),
    .reset     (reset),
    .tmr_we    (tmr_we),
    .tmr_addr  (tmr_addr),
    .tmr_wdata (tmr_wdata),
    .tmr_rdata (tmr_rdata),
    .mtip      (mtip)
  );

  always_ff @(posedge clk_o) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], ext_irq};
  end

  assign meip = sync[SYNC_STAGES-1];

  always_comb begin
    mip               = '0;
    mip[MIP_MEIP_BIT] = meip;
    mip[MIP_MTIP_BIT] = mtip;
  end

  assign take_ext = meip & mie_meie & mstatus_mie;
  assign take_tmr = mtip & mie_mtie & mstatus_mie;

  // Enables are only sampled in IDLE, so a trap that has started always completes.
  always_ff @(posedge clk_o) begin
    if (reset) begin
      state      <= IDLE;
      intrrupt   <= 1'b0;
      csr_mcause <= '0;
      in_service <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take_ext || take_tmr) begin
            state      <= ISSUE;
            intrrupt   <= 1'b1;
            in_service <= 1'b1;
            csr_mcause <= take_ext ? MCAUSE_MEI : MCAUSE_MTI;
          end
        end
        ISSUE: begin
          state    <= SERVICE;
          intrrupt <= 1'b0;
        end
        SERVICE: begin
          if (mret_i) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          intrrupt   <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed self-checking bench for irq_ctrl
module tb_irq_ctrl;

  logic        clk_o = 1'b0;
  logic        reset;
  logic        ext_irq;
  logic        mstatus_mie;
  logic        mie_meie;
  logic        mie_mtie;
  logic        mret_i;
  logic        tmr_we;
  logic        tmr_addr;
  logic [31:0] tmr_wdata;
  logic [31:0] tmr_rdata;
  logic        intrrupt;
  logic [31:0] csr_mcause;
  logic [31:0] mip;
  logic        in_service;

  int n_cmp = 0;
  int n_bad = 0;

  irq_ctrl #(.PRESCALE(4), .SYNC_STAGES(2)) dut (
    .clk_o       (clk_o),
    .reset       (reset),
    .ext_irq     (ext_irq),
    .mstatus_mie (mstatus_mie),
    .mie_meie    (mie_meie),
    .mie_mtie    (mie_mtie),
    .mret_i      (mret_i),
    .tmr_we      (tmr_we),
    .tmr_addr    (tmr_addr),
    .tmr_wdata   (tmr_wdata),
    .tmr_rdata   (tmr_rdata),
    .intrrupt    (intrrupt),
    .csr_mcause  (csr_mcause),
    .mip         (mip),
    .in_service  (in_service)
  );

  always #5 clk_o = ~clk_o;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_o);
    @(negedge clk_o);
  endtask

  task automatic tmr_write(input logic addr, input logic [31:0] data);
    tmr_we    = 1'b1;
    tmr_addr  = addr;
    tmr_wdata = data;
    step();
    tmr_we    = 1'b0;
    tmr_addr  = 1'b0;
  endtask

  task automatic read_tmr(input logic addr, input string tag, input logic [31:0] exp);
    tmr_addr = addr;
    #1;
    check_eq(tag, tmr_rdata, exp);
  endtask

  task automatic mret_pulse();
    mret_i = 1'b1;
    step();
    mret_i = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ext_irq = 1'b0; mstatus_mie = 1'b0; mie_meie = 1'b0; mie_mtie = 1'b0;
    mret_i = 1'b0; tmr_we = 1'b0; tmr_addr = 1'b0; tmr_wdata = '0;
    @(negedge clk_o);
    step();
    step();
    reset = 1'b0;

    // reset state
    read_tmr(1'b0, "rst_mtime", 32'h0);
    read_tmr(1'b1, "rst_mtimecmp", 32'hFFFF_FFFF);
    tmr_addr = 1'b0;
    check_eq("rst_mcause", csr_mcause, 32'h0);
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("idle_intr", {31'b0, intrrupt}, 32'h0);
      check_eq("idle_mip", mip, 32'h0);
      check_eq("idle_insvc", {31'b0, in_service}, 32'h0);
    end

    // external interrupt latency and single issue until mret
    mstatus_mie = 1'b1; mie_meie = 1'b1; ext_irq = 1'b1;
    step();
    check_eq("ext_n_mip", mip, 32'h0);
    step();
    check_eq("ext_n1_mip", mip, 32'h0000_0800);
    check_eq("ext_n1_intr", {31'b0, intrrupt}, 32'h0);
    step();
    check_eq("ext_n2_intr", {31'b0, intrrupt}, 32'h1);
    check_eq("ext_mcause", csr_mcause, 32'h8000_000B);
    check_eq("ext_n2_insvc", {31'b0, in_service}, 32'h1);
    step();
    check_eq("ext_pulse_end", {31'b0, intrrupt}, 32'h0);
    check_eq("ext_svc", {31'b0, in_service}, 32'h1);
    ext_irq = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_eq("ext_svc_hold", {31'b0, in_service}, 32'h1);
    check_eq("ext_mip_clr", mip, 32'h0);
    ext_irq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("ext_no_2nd", {31'b0, intrrupt}, 32'h0);
    end
    mret_pulse();
    check_eq("mret_insvc", {31'b0, in_service}, 32'h0);
    check_eq("mret_gap_intr", {31'b0, intrrupt}, 32'h0);
    step();
    check_eq("ext_2nd_intr", {31'b0, intrrupt}, 32'h1);
    check_eq("ext_2nd_mcause", csr_mcause, 32'h8000_000B);
    step();
    ext_irq = 1'b0;
    for (int i = 0; i < 3; i++) step();
    mret_pulse();
    check_eq("ext_done_insvc", {31'b0, in_service}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("ext_quiet", {31'b0, intrrupt}, 32'h0);
    end
    mie_meie = 1'b0;

    // timer: PRESCALE=4, mtimecmp=5, mtime=0
    tmr_write(1'b1, 32'd5);
    tmr_write(1'b0, 32'd0);
    mie_mtie = 1'b1;
    for (int i = 1; i < 20; i++) begin
      step();
      check_eq("tmr_wait_mip", mip, 32'h0);
      check_eq("tmr_wait_intr", {31'b0, intrrupt}, 32'h0);
    end
    step();
    check_eq("tmr_mip", mip, 32'h0000_0080);
    check_eq("tmr_mtime5", tmr_rdata, 32'd5);
    check_eq("tmr_not_yet", {31'b0, intrrupt}, 32'h0);
    step();
    check_eq("tmr_intr", {31'b0, intrrupt}, 32'h1);
    check_eq("tmr_mcause", csr_mcause, 32'h8000_0007);
    step();
    check_eq("tmr_pulse_end", {31'b0, intrrupt}, 32'h0);
    tmr_write(1'b1, 32'hFFFF_FFFF);
    check_eq("tmr_mip_clr", mip, 32'h0);
    mret_pulse();
    check_eq("tmr_done_insvc", {31'b0, in_service}, 32'h0);
    step();
    check_eq("tmr_quiet", {31'b0, intrrupt}, 32'h0);

    // both pending with global enable low, then priority and post-mret gap
    mstatus_mie = 1'b0; mie_meie = 1'b1; mie_mtie = 1'b1; ext_irq = 1'b1;
    tmr_write(1'b1, 32'h0);
    step();
    step();
    check_eq("both_mip", mip, 32'h0000_0880);
    check_eq("both_masked", {31'b0, intrrupt}, 32'h0);
    check_eq("both_masked_svc", {31'b0, in_service}, 32'h0);
    step();
    check_eq("both_masked2", {31'b0, intrrupt}, 32'h0);
    mstatus_mie = 1'b1;
    step();
    check_eq("prio_intr", {31'b0, intrrupt}, 32'h1);
    check_eq("prio_mcause", csr_mcause, 32'h8000_000B);
    step();
    ext_irq = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_eq("prio_mip_tmr", mip, 32'h0000_0080);
    mret_pulse();
    check_eq("prio_gap", {31'b0, intrrupt}, 32'h0);
    check_eq("prio_gap_svc", {31'b0, in_service}, 32'h0);
    step();
    check_eq("prio_tmr_intr", {31'b0, intrrupt}, 32'h1);
    check_eq("prio_tmr_mcause", csr_mcause, 32'h8000_0007);
    step();
    tmr_write(1'b1, 32'hFFFF_FFFF);
    mret_pulse();
    check_eq("prio_done_svc", {31'b0, in_service}, 32'h0);
    mie_meie = 1'b0; mie_mtie = 1'b0;

    // mtime wrap
    tmr_write(1'b0, 32'hFFFF_FFFF);
    read_tmr(1'b0, "wrap_pre", 32'hFFFF_FFFF);
    check_eq("wrap_pre_mip", mip, 32'h0000_0080);
    for (int i = 0; i < 3; i++) step();
    read_tmr(1'b0, "wrap_hold", 32'hFFFF_FFFF);
    step();
    read_tmr(1'b0, "wrap_zero", 32'h0);
    check_eq("wrap_mip", mip, 32'h0);

    // reset while in SERVICE
    tmr_write(1'b1, 32'd123);
    mie_meie = 1'b1; ext_irq = 1'b1;
    step();
    step();
    step();
    check_eq("svc_rst_issue", {31'b0, intrrupt}, 32'h1);
    step();
    check_eq("svc_rst_pre", {31'b0, in_service}, 32'h1);
    reset = 1'b1; ext_irq = 1'b0;
    step();
    check_eq("svc_rst_insvc", {31'b0, in_service}, 32'h0);
    check_eq("svc_rst_intr", {31'b0, intrrupt}, 32'h0);
    check_eq("svc_rst_mcause", csr_mcause, 32'h0);
    check_eq("svc_rst_mip", mip, 32'h0);
    read_tmr(1'b1, "svc_rst_cmp", 32'hFFFF_FFFF);
    read_tmr(1'b0, "svc_rst_mtime", 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("post_rst_quiet", {31'b0, intrrupt}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
